memory_read: RTL and testbench
==============================

// Module: memory_read
// PURPOSE
//   Host-side readback engine for the NPU weight/image RAMs, mirroring the loader's layout.
//   After start it walks image banks, conv RAM, then dense banks in load order.
//   Each host read returns one 32-bit word packed exactly as the loader split it.
//   Drives the B-port addresses of the same RAMs; sits beside the loader behind the Avalon slave.
// PARAMETERS
//   IMAGE_WORDS  225    words per image bank set (4 x 8-bit banks, one word = 4 bytes)
//   CONV_BYTES   18816  conv RAM entries (8-bit)
//   DENSE_WORDS  4203   words per dense bank set (4 x 8-bit banks)
// PORTS
//   clk                 in   1   system clock
//   reset               in   1   asynchronous, active-low reset
//   control_reg         in   32  host control; 32'h0002 = start readback, 32'h0000 = clear/abort
//   read                in   1   host read strobe, one word per accepted cycle
//   image_q0..image_q3  in   8   image bank B-port data, 1-cycle RAM latency
//   conv_q              in   8   conv RAM B-port data, 1-cycle RAM latency
//   dense_q0..dense_q3  in   8   dense bank B-port data, 1-cycle RAM latency
//   image_ram_addr_b    out  10  image bank read address
//   conv_ram_addr_b     out  15  conv RAM read address
//   dense_ram_addr_b    out  15  dense bank read address
//   readdata            out  32  returned word
//   readdatavalid       out  1   one-cycle pulse, readdata valid
//   busy                out  1   1 in RD_IMAGE/RD_CONV/RD_DENSE
//   done                out  1   1 in DONE
//   overrun             out  1   sticky: read arrived during settle cycle
// BEHAVIOUR
//   Reset (reset=0): state IDLE; all addresses, readdata, readdatavalid, busy, done and overrun are 0.
//   States: IDLE -> RD_IMAGE -> RD_CONV -> RD_DENSE -> DONE -> IDLE.
//   IDLE -> RD_IMAGE when control_reg==32'h0002; addresses 0, settle=1, overrun cleared.
//   Addr reg always holds the next item. settle=1 the cycle after any address change (RAM q stale).
//   Read accepted at edge T when busy and settle==0:
//     - readdata <= packed q, readdatavalid=1 during T+1, address += 1, settle=1 during T+1.
//   Read when busy and settle==1: ignored, no readdatavalid, overrun <= 1 (sticky until next start).
//   Packing: image/dense {q0,q1,q2,q3} -> [31:24],[23:16],[15:8],[7:0]; conv {24'h0,conv_q}.
//   Segment switch on accepting last item of the segment:
//     - RD_IMAGE index IMAGE_WORDS-1 -> RD_CONV, conv addr 0.
//     - RD_CONV index CONV_BYTES-1 -> RD_DENSE, dense addr 0.
//     - RD_DENSE index DENSE_WORDS-1 -> DONE.
//     - The settle rule applies across the switch.
//   Inactive segment addresses hold 0.
//   Read in IDLE or DONE: readdata=32'h0, readdatavalid pulse next cycle, no state/addr change.
//   DONE holds while control_reg==32'h0002; exits to IDLE when control_reg!=32'h0002 (no auto-restart).
//   Abort: control_reg==32'h0000 in any busy state -> IDLE next cycle, addresses zeroed.
//     - A read accepted in the abort cycle still returns its word.
//   Async reset mid-operation: immediate return to reset values; no partial word emitted.
//   Address arithmetic is width-exact; counters never exceed segment size-1 (no wrap).
// TESTING
//   1. Preload image banks addr0 = AA,BB,CC,DD; start, wait 1 cycle, read -> readdata 32'hAABBCCDD, rdv 1 cycle, image addr -> 1.
//   2. Read on back-to-back cycles -> 2nd read ignored, overrun=1, image addr advances only by 1.
//   3. Read 225 image words -> state RD_CONV, conv addr 0; conv_q=8'h5A -> readdata 32'h0000005A.
//   4. Full sweep 225+18816+4203 reads with settle gaps -> done=1, busy=0, every word matches preload, overrun=0.
//   5. control_reg=0 mid-RD_CONV at conv addr 100 -> IDLE next cycle, addrs 0; restart reads image addr 0 first.
//   6. Assert reset mid-RD_DENSE -> all outputs 0 asynchronously; read in IDLE -> readdata 32'h0 with rdv pulse.

Source files
------------

// File: rtl/memory_read.sv
// rtl/memory_read.sv - host readback engine walking image, conv and dense RAMs in loader order
// One 32-bit word per accepted read; a settle cycle follows every address change.
module memory_read #(
    parameter int IMAGE_WORDS = 225,
    parameter int CONV_BYTES  = 18816,
    parameter int DENSE_WORDS = 4203
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] control_reg,
    input  logic        read,
    input  logic [7:0]  image_q0,
    input  logic [7:0]  image_q1,
    input  logic [7:0]  image_q2,
    input  logic [7:0]  image_q3,
    input  logic [7:0]  conv_q,
    input  logic [7:0]  dense_q0,
    input  logic [7:0]  dense_q1,
    input  logic [7:0]  dense_q2,
    input  logic [7:0]  dense_q3,
    output logic [9:0]  image_ram_addr_b,
    output logic [14:0] conv_ram_addr_b,
    output logic [14:0] dense_ram_addr_b,
    output logic [31:0] readdata,
    output logic        readdatavalid,
    output logic        busy,
    output logic        done,
    output logic        overrun
);
    localparam logic [31:0] CTRL_START = 32'h0000_0002;
    localparam logic [31:0] CTRL_CLEAR = 32'h0000_0000;
    localparam logic [9:0]  IMAGE_LAST = 10'(IMAGE_WORDS - 1);
    localparam logic [14:0] CONV_LAST  = 15'(CONV_BYTES - 1);
    localparam logic [14:0] DENSE_LAST = 15'(DENSE_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_IMAGE,
        S_RD_CONV,
        S_RD_DENSE,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [9:0]  r_image_addr;
    logic [9:0]  w_image_addr_next;
    logic [14:0] r_conv_addr;
    logic [14:0] w_conv_addr_next;
    logic [14:0] r_dense_addr;
    logic [14:0] w_dense_addr_next;
    logic        r_settle;
    logic        w_settle_next;
    logic [31:0] r_readdata;
    logic [31:0] w_readdata_next;
    logic        r_rdv;
    logic        w_rdv_next;
    logic        r_overrun;
    logic        w_overrun_next;

    logic        w_busy;
    logic        w_accept;
    logic [31:0] w_packed;

    assign w_busy   = (r_state == S_RD_IMAGE) || (r_state == S_RD_CONV) || (r_state == S_RD_DENSE);
    assign w_accept = w_busy && read && !r_settle;

    always_comb begin
        w_packed = 32'h0;
        case (r_state)
            S_RD_IMAGE: w_packed = {image_q0, image_q1, image_q2, image_q3};
            S_RD_CONV:  w_packed = {24'h0, conv_q};
            S_RD_DENSE: w_packed = {dense_q0, dense_q1, dense_q2, dense_q3};
            default:    w_packed = 32'h0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_image_addr <= 10'd0;
            r_conv_addr  <= 15'd0;
            r_dense_addr <= 15'd0;
            r_settle     <= 1'b0;
            r_readdata   <= 32'h0;
            r_rdv        <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_image_addr <= w_image_addr_next;
            r_conv_addr  <= w_conv_addr_next;
            r_dense_addr <= w_dense_addr_next;
            r_settle     <= w_settle_next;
            r_readdata   <= w_readdata_next;
            r_rdv        <= w_rdv_next;
            r_overrun    <= w_overrun_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_image_addr_next = r_image_addr;
        w_conv_addr_next  = r_conv_addr;
        w_dense_addr_next = r_dense_addr;
        w_settle_next     = 1'b0;
        w_readdata_next   = r_readdata;
        w_rdv_next        = 1'b0;
        w_overrun_next    = r_overrun;

        case (r_state)
            S_IDLE: begin
                if (read) begin
                    w_readdata_next = 32'h0;
                    w_rdv_next      = 1'b1;
                end
                if (control_reg == CTRL_START) begin
                    w_state_next      = S_RD_IMAGE;
                    w_image_addr_next = 10'd0;
                    w_conv_addr_next  = 15'd0;
                    w_dense_addr_next = 15'd0;
                    w_settle_next     = 1'b1;
                    w_overrun_next    = 1'b0;
                end
            end
            S_RD_IMAGE, S_RD_CONV, S_RD_DENSE: begin
                if (read && r_settle) begin
                    w_overrun_next = 1'b1;
                end
                if (w_accept) begin
                    w_readdata_next = w_packed;
                    w_rdv_next      = 1'b1;
                    w_settle_next   = 1'b1;
                    // The finished segment's address returns to 0 so inactive banks always read 0.
                    if (r_state == S_RD_IMAGE) begin
                        if (r_image_addr == IMAGE_LAST) begin
                            w_state_next      = S_RD_CONV;
                            w_image_addr_next = 10'd0;
                            w_conv_addr_next  = 15'd0;
                        end else begin
                            w_image_addr_next = r_image_addr + 10'd1;
                        end
                    end else if (r_state == S_RD_CONV) begin
                        if (r_conv_addr == CONV_LAST) begin
                            w_state_next      = S_RD_DENSE;
                            w_conv_addr_next  = 15'd0;
                            w_dense_addr_next = 15'd0;
                        end else begin
                            w_conv_addr_next = r_conv_addr + 15'd1;
                        end
                    end else begin
                        if (r_dense_addr == DENSE_LAST) begin
                            w_state_next      = S_DONE;
                            w_dense_addr_next = 15'd0;
                        end else begin
                            w_dense_addr_next = r_dense_addr + 15'd1;
                        end
                    end
                end
                // Abort wins over the walk, but a word accepted this cycle is still delivered.
                if (control_reg == CTRL_CLEAR) begin
                    w_state_next      = S_IDLE;
                    w_image_addr_next = 10'd0;
                    w_conv_addr_next  = 15'd0;
                    w_dense_addr_next = 15'd0;
                    w_settle_next     = 1'b0;
                end
            end
            S_DONE: begin
                if (read) begin
                    w_readdata_next = 32'h0;
                    w_rdv_next      = 1'b1;
                end
                if (control_reg != CTRL_START) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign image_ram_addr_b = r_image_addr;
    assign conv_ram_addr_b  = r_conv_addr;
    assign dense_ram_addr_b = r_dense_addr;
    assign readdata         = r_readdata;
    assign readdatavalid    = r_rdv;
    assign busy             = w_busy;
    assign done             = (r_state == S_DONE);
    assign overrun          = r_overrun;
endmodule

// File: tb/tb_memory_read.sv
// tb/tb_memory_read.sv - directed self-checking bench for memory_read with behavioural B-port RAMs
module tb_memory_read;
    localparam int IMAGE_WORDS = 225;
    localparam int CONV_BYTES  = 18816;
    localparam int DENSE_WORDS = 4203;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] control_reg;
    logic        read;
    logic [7:0]  image_q0, image_q1, image_q2, image_q3;
    logic [7:0]  conv_q;
    logic [7:0]  dense_q0, dense_q1, dense_q2, dense_q3;
    logic [9:0]  image_ram_addr_b;
    logic [14:0] conv_ram_addr_b;
    logic [14:0] dense_ram_addr_b;
    logic [31:0] readdata;
    logic        readdatavalid;
    logic        busy;
    logic        done;
    logic        overrun;

    logic [7:0] img_mem   [0:3][0:1023];
    logic [7:0] conv_mem  [0:32767];
    logic [7:0] dense_mem [0:3][0:32767];

    int checks = 0;
    int errors = 0;

    memory_read #(
        .IMAGE_WORDS(IMAGE_WORDS),
        .CONV_BYTES (CONV_BYTES),
        .DENSE_WORDS(DENSE_WORDS)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .control_reg     (control_reg),
        .read            (read),
        .image_q0        (image_q0),
        .image_q1        (image_q1),
        .image_q2        (image_q2),
        .image_q3        (image_q3),
        .conv_q          (conv_q),
        .dense_q0        (dense_q0),
        .dense_q1        (dense_q1),
        .dense_q2        (dense_q2),
        .dense_q3        (dense_q3),
        .image_ram_addr_b(image_ram_addr_b),
        .conv_ram_addr_b (conv_ram_addr_b),
        .dense_ram_addr_b(dense_ram_addr_b),
        .readdata        (readdata),
        .readdatavalid   (readdatavalid),
        .busy            (busy),
        .done            (done),
        .overrun         (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        image_q0 <= img_mem[0][image_ram_addr_b];
        image_q1 <= img_mem[1][image_ram_addr_b];
        image_q2 <= img_mem[2][image_ram_addr_b];
        image_q3 <= img_mem[3][image_ram_addr_b];
        conv_q   <= conv_mem[conv_ram_addr_b];
        dense_q0 <= dense_mem[0][dense_ram_addr_b];
        dense_q1 <= dense_mem[1][dense_ram_addr_b];
        dense_q2 <= dense_mem[2][dense_ram_addr_b];
        dense_q3 <= dense_mem[3][dense_ram_addr_b];
    end

    function automatic logic [31:0] img_word(input int i);
        return {img_mem[0][i], img_mem[1][i], img_mem[2][i], img_mem[3][i]};
    endfunction

    function automatic logic [31:0] conv_word(input int i);
        return {24'h0, conv_mem[i]};
    endfunction

    function automatic logic [31:0] dense_word(input int i);
        return {dense_mem[0][i], dense_mem[1][i], dense_mem[2][i], dense_mem[3][i]};
    endfunction

    // Called at a negedge with settle clear; returns one word and leaves a settle gap.
    task automatic read_word(output logic [31:0] data, output logic valid);
        read = 1'b1;
        @(negedge clk);
        read = 1'b0;
        data  = readdata;
        valid = readdatavalid;
        @(negedge clk);
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++;
        if ({busy, done, overrun, readdatavalid} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags got %b want 0000", {busy, done, overrun, readdatavalid});
        end
        checks++;
        if ({readdata, image_ram_addr_b, conv_ram_addr_b, dense_ram_addr_b} !== 72'h0) begin
            errors++;
            $display("FAIL reset_data_addr got rd=%h img=%0d conv=%0d dense=%0d want all 0",
                     readdata, image_ram_addr_b, conv_ram_addr_b, dense_ram_addr_b);
        end
    endtask

    task automatic test_first_word;
        logic [31:0] d;
        logic        v;
        reset = 1'b1;
        @(negedge clk);
        control_reg = 32'h2;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || image_ram_addr_b !== 10'd0) begin
            errors++;
            $display("FAIL start_state got busy=%b img=%0d want busy=1 img=0", busy, image_ram_addr_b);
        end
        @(negedge clk);
        read_word(d, v);
        checks++;
        if (d !== 32'hAABBCCDD || v !== 1'b1) begin
            errors++;
            $display("FAIL first_word got %h rdv=%b want aabbccdd rdv=1", d, v);
        end
        checks++;
        if (image_ram_addr_b !== 10'd1 || readdatavalid !== 1'b0) begin
            errors++;
            $display("FAIL first_word_after got img=%0d rdv=%b want img=1 rdv=0", image_ram_addr_b, readdatavalid);
        end
    endtask

    task automatic test_back_to_back;
        read = 1'b1;
        @(negedge clk);
        checks++;
        if (readdatavalid !== 1'b1 || readdata !== img_word(1) || image_ram_addr_b !== 10'd2) begin
            errors++;
            $display("FAIL b2b_first got rdv=%b rd=%h img=%0d want rdv=1 rd=%h img=2",
                     readdatavalid, readdata, image_ram_addr_b, img_word(1));
        end
        @(negedge clk);
        read = 1'b0;
        checks++;
        if (readdatavalid !== 1'b0 || overrun !== 1'b1 || image_ram_addr_b !== 10'd2) begin
            errors++;
            $display("FAIL b2b_second got rdv=%b ovr=%b img=%0d want rdv=0 ovr=1 img=2",
                     readdatavalid, overrun, image_ram_addr_b);
        end
        @(negedge clk);
    endtask

    task automatic test_segment_switch;
        logic [31:0] d;
        logic        v;
        int          bad;
        bad = 0;
        for (int i = 2; i < IMAGE_WORDS; i++) begin
            read_word(d, v);
            if (d !== img_word(i) || v !== 1'b1) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL image_words got %0d bad words want 0", bad);
        end
        checks++;
        if (busy !== 1'b1 || image_ram_addr_b !== 10'd0 || conv_ram_addr_b !== 15'd0) begin
            errors++;
            $display("FAIL to_conv got busy=%b img=%0d conv=%0d want busy=1 img=0 conv=0",
                     busy, image_ram_addr_b, conv_ram_addr_b);
        end
        read_word(d, v);
        checks++;
        if (d !== 32'h0000005A || v !== 1'b1 || conv_ram_addr_b !== 15'd1) begin
            errors++;
            $display("FAIL conv_first got %h rdv=%b conv=%0d want 0000005a rdv=1 conv=1", d, v, conv_ram_addr_b);
        end
    endtask

    task automatic test_abort;
        logic [31:0] d;
        logic        v;
        int          bad;
        bad = 0;
        for (int i = 1; i < 100; i++) begin
            read_word(d, v);
            if (d !== conv_word(i) || v !== 1'b1) bad++;
        end
        checks++;
        if (bad !== 0 || conv_ram_addr_b !== 15'd100) begin
            errors++;
            $display("FAIL conv_to_100 got bad=%0d conv=%0d want bad=0 conv=100", bad, conv_ram_addr_b);
        end
        control_reg = 32'h0;
        read = 1'b1;
        @(negedge clk);
        read = 1'b0;
        checks++;
        if (readdatavalid !== 1'b1 || readdata !== conv_word(100)) begin
            errors++;
            $display("FAIL abort_word got rdv=%b rd=%h want rdv=1 rd=%h", readdatavalid, readdata, conv_word(100));
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || {image_ram_addr_b, conv_ram_addr_b, dense_ram_addr_b} !== 40'h0) begin
            errors++;
            $display("FAIL abort_idle got busy=%b done=%b img=%0d conv=%0d dense=%0d want idle, addrs 0",
                     busy, done, image_ram_addr_b, conv_ram_addr_b, dense_ram_addr_b);
        end
        control_reg = 32'h2;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || overrun !== 1'b0 || image_ram_addr_b !== 10'd0) begin
            errors++;
            $display("FAIL restart got busy=%b ovr=%b img=%0d want busy=1 ovr=0 img=0", busy, overrun, image_ram_addr_b);
        end
        @(negedge clk);
        read_word(d, v);
        checks++;
        if (d !== 32'hAABBCCDD || v !== 1'b1 || image_ram_addr_b !== 10'd1) begin
            errors++;
            $display("FAIL restart_word got %h rdv=%b img=%0d want aabbccdd rdv=1 img=1", d, v, image_ram_addr_b);
        end
    endtask

    task automatic test_full_sweep;
        logic [31:0] d;
        logic        v;
        logic [31:0] e;
        int          bad;
        int          first_bad;
        bad = 0;
        first_bad = -1;
        control_reg = 32'h0;
        @(negedge clk);
        control_reg = 32'h2;
        @(negedge clk);
        @(negedge clk);
        for (int n = 0; n < IMAGE_WORDS + CONV_BYTES + DENSE_WORDS; n++) begin
            if (n < IMAGE_WORDS) e = img_word(n);
            else if (n < IMAGE_WORDS + CONV_BYTES) e = conv_word(n - IMAGE_WORDS);
            else e = dense_word(n - IMAGE_WORDS - CONV_BYTES);
            read_word(d, v);
            if (d !== e || v !== 1'b1) begin
                if (bad == 0) first_bad = n;
                bad++;
            end
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL sweep_data got %0d bad words (first at %0d) want 0", bad, first_bad);
        end
        checks++;
        if ({done, busy, overrun} !== 3'b100) begin
            errors++;
            $display("FAIL sweep_end got done=%b busy=%b ovr=%b want done=1 busy=0 ovr=0", done, busy, overrun);
        end
        checks++;
        if ({image_ram_addr_b, conv_ram_addr_b, dense_ram_addr_b} !== 40'h0) begin
            errors++;
            $display("FAIL sweep_addrs got img=%0d conv=%0d dense=%0d want 0", image_ram_addr_b, conv_ram_addr_b, dense_ram_addr_b);
        end
        read_word(d, v);
        checks++;
        if (d !== 32'h0 || v !== 1'b1 || done !== 1'b1) begin
            errors++;
            $display("FAIL done_read got %h rdv=%b done=%b want 0 rdv=1 done=1", d, v, done);
        end
        control_reg = 32'h0;
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL done_exit got done=%b busy=%b want 0 0", done, busy);
        end
    endtask

    task automatic test_reset_mid_dense;
        logic [31:0] d;
        logic        v;
        control_reg = 32'h2;
        @(negedge clk);
        @(negedge clk);
        for (int n = 0; n < IMAGE_WORDS + CONV_BYTES + 3; n++) read_word(d, v);
        checks++;
        if (busy !== 1'b1 || dense_ram_addr_b !== 15'd3 || readdata !== dense_word(2)) begin
            errors++;
            $display("FAIL reach_dense got busy=%b dense=%0d rd=%h want busy=1 dense=3 rd=%h",
                     busy, dense_ram_addr_b, readdata, dense_word(2));
        end
        read = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({readdata, image_ram_addr_b, conv_ram_addr_b, dense_ram_addr_b} !== 72'h0 ||
            {busy, done, overrun, readdatavalid} !== 4'b0000) begin
            errors++;
            $display("FAIL async_reset got rd=%h dense=%0d flags=%b want all 0",
                     readdata, dense_ram_addr_b, {busy, done, overrun, readdatavalid});
        end
        @(negedge clk);
        checks++;
        if (readdatavalid !== 1'b0 || readdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_no_word got rdv=%b rd=%h want 0 0", readdatavalid, readdata);
        end
        control_reg = 32'h0;
        reset = 1'b1;
        @(negedge clk);
        read = 1'b0;
        checks++;
        if (readdatavalid !== 1'b1 || readdata !== 32'h0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_read got rdv=%b rd=%h busy=%b want 1 0 0", readdatavalid, readdata, busy);
        end
        @(negedge clk);
        checks++;
        if (readdatavalid !== 1'b0) begin
            errors++;
            $display("FAIL idle_read_pulse got rdv=%b want 0", readdatavalid);
        end
    endtask

    initial begin
        reset = 1'b0;
        control_reg = 32'h0;
        read = 1'b0;
        for (int a = 0; a < 1024; a++)
            for (int b = 0; b < 4; b++) img_mem[b][a] = 8'(a * 7 + b * 61 + 3);
        for (int a = 0; a < 32768; a++) begin
            conv_mem[a] = 8'(a ^ (a >> 7) ^ 8'h5A);
            for (int b = 0; b < 4; b++) dense_mem[b][a] = 8'(a * 3 + (a >> 8) * 17 + b * 29 + 1);
        end
        img_mem[0][0] = 8'hAA;
        img_mem[1][0] = 8'hBB;
        img_mem[2][0] = 8'hCC;
        img_mem[3][0] = 8'hDD;

        test_reset;
        test_first_word;
        test_back_to_back;
        test_segment_switch;
        test_abort;
        test_full_sweep;
        test_reset_mid_dense;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
